// File: rtl/imcor_pkg.sv
// Shared types and constants for the imcor over-exposure ratio path:
// sample widths, default divider latency, in-flight tag encoding and quotient saturation.
package imcor_pkg;

   localparam int IMCOR_DW_IN   = 10;
   localparam int IMCOR_DW_DEC  = 8;
   localparam int IMCOR_DIV_LAT = 4;
   localparam int IMCOR_DW_Q    = IMCOR_DW_IN + IMCOR_DW_DEC;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_R    = 2'd1,
      TAG_B    = 2'd2
   } tag_e;

   // Divide-by-zero wins; otherwise a full-scale integer part discards the fraction.
   function automatic logic [IMCOR_DW_Q-1:0] sat_quot(input logic [IMCOR_DW_Q-1:0] quot,
                                                      input logic                  dbz);
      logic [IMCOR_DW_IN-1:0] int_part;
      int_part = quot[IMCOR_DW_Q-1:IMCOR_DW_DEC];
      if (dbz) begin
         return {{IMCOR_DW_IN{1'b1}}, {IMCOR_DW_DEC{1'b0}}};
      end else if (&int_part) begin
         return {int_part, {IMCOR_DW_DEC{1'b0}}};
      end else begin
         return quot;
      end
   endfunction

endpackage

// File: rtl/imcor_rr_arb2.sv
// Two-input round-robin arbiter (bit 0 = R, bit 1 = B) owning the priority pointer.
// ptr_upd strobes whenever a grant is made, which is also when the pointer moves.
module imcor_rr_arb2
   import imcor_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       ptr_upd
);

   logic ptr_q;
   logic ptr_d;

   // Pointer 0 favours R. The winner hands priority to the other side, even when uncontended.
   always_comb begin
      gnt     = 2'b00;
      ptr_d   = ptr_q;
      ptr_upd = 1'b0;
      if (!rst) begin
         if (req[0] && (!req[1] || !ptr_q)) begin
            gnt     = 2'b01;
            ptr_d   = 1'b1;
            ptr_upd = 1'b1;
         end else if (req[1]) begin
            gnt     = 2'b10;
            ptr_d   = 1'b0;
            ptr_upd = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/imcor_div_arbiter.sv
// Shares one pipelined divider between the R/G and B/G ratio requesters, steering saturated
// quotients back by tag. Define IMCOR_DIV_STATS_EN for per-frame grant/dbz statistics.
module imcor_div_arbiter
   import imcor_pkg::*;
#(
   parameter int DW_IN   = IMCOR_DW_IN,
   parameter int DW_DEC  = IMCOR_DW_DEC,
   parameter int DIV_LAT = IMCOR_DIV_LAT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vsync,
   input  logic                    req_r_valid,
   input  logic [DW_IN-1:0]        req_r_num,
   input  logic [DW_IN-1:0]        req_r_den,
   output logic                    req_r_ready,
   input  logic                    req_b_valid,
   input  logic [DW_IN-1:0]        req_b_num,
   input  logic [DW_IN-1:0]        req_b_den,
   output logic                    req_b_ready,
   output logic [DW_IN+DW_DEC-1:0] div_a,
   output logic [DW_IN-1:0]        div_b,
   output logic                    div_vld,
   input  logic [DW_IN+DW_DEC-1:0] div_quot,
   input  logic                    div_dbz,
   output logic                    rsp_r_valid,
   output logic [DW_IN+DW_DEC-1:0] rsp_r_quot,
   output logic                    rsp_b_valid,
   output logic [DW_IN+DW_DEC-1:0] rsp_b_quot,
   output logic                    busy
`ifdef IMCOR_DIV_STATS_EN
   ,
   output logic [15:0]             stat_r_cnt,
   output logic [15:0]             stat_b_cnt,
   output logic [15:0]             stat_dbz_cnt
`endif
);

   localparam int DW_Q = DW_IN + DW_DEC;

   logic [1:0]      gnt;
   logic            ptr_upd;

   logic [DW_Q-1:0]  div_a_q, div_a_d;
   logic [DW_IN-1:0] div_b_q, div_b_d;
   logic             div_vld_q, div_vld_d;

   // Stage 0 lines up with the operands on div_a/div_b, stage DIV_LAT with div_quot.
   tag_e tag_q [DIV_LAT+1];
   tag_e tag_d [DIV_LAT+1];
   tag_e tag_exit;

   logic            rsp_r_valid_q, rsp_r_valid_d;
   logic            rsp_b_valid_q, rsp_b_valid_d;
   logic [DW_Q-1:0] rsp_r_quot_q, rsp_r_quot_d;
   logic [DW_Q-1:0] rsp_b_quot_q, rsp_b_quot_d;
   logic [DW_Q-1:0] quot_sat;
   logic            inflight;

   imcor_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req_b_valid, req_r_valid}),
      .gnt     (gnt),
      .ptr_upd (ptr_upd)
   );

   assign req_r_ready = gnt[0];
   assign req_b_ready = gnt[1];

   // Operands only change on a grant so an idle divider sees stable inputs.
   always_comb begin
      div_vld_d = ptr_upd;
      div_a_d   = div_a_q;
      div_b_d   = div_b_q;
      tag_d[0]  = TAG_NONE;
      if (gnt[0]) begin
         div_a_d  = {req_r_num, {DW_DEC{1'b0}}};
         div_b_d  = req_r_den;
         tag_d[0] = TAG_R;
      end else if (gnt[1]) begin
         div_a_d  = {req_b_num, {DW_DEC{1'b0}}};
         div_b_d  = req_b_den;
         tag_d[0] = TAG_B;
      end
      for (int i = 1; i <= DIV_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   assign tag_exit = tag_q[DIV_LAT];
   assign quot_sat = sat_quot(div_quot, div_dbz);

   always_comb begin
      rsp_r_valid_d = (tag_exit == TAG_R);
      rsp_b_valid_d = (tag_exit == TAG_B);
      rsp_r_quot_d  = rsp_r_valid_d ? quot_sat : rsp_r_quot_q;
      rsp_b_quot_d  = rsp_b_valid_d ? quot_sat : rsp_b_quot_q;
   end

   always_comb begin
      inflight = rsp_r_valid_q | rsp_b_valid_q;
      for (int i = 0; i <= DIV_LAT; i++) begin
         inflight = inflight | (tag_q[i] != TAG_NONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_a_q       <= '0;
         div_b_q       <= '0;
         div_vld_q     <= 1'b0;
         rsp_r_valid_q <= 1'b0;
         rsp_b_valid_q <= 1'b0;
         rsp_r_quot_q  <= '0;
         rsp_b_quot_q  <= '0;
         for (int i = 0; i <= DIV_LAT; i++) begin
            tag_q[i] <= TAG_NONE;
         end
      end else begin
         div_a_q       <= div_a_d;
         div_b_q       <= div_b_d;
         div_vld_q     <= div_vld_d;
         rsp_r_valid_q <= rsp_r_valid_d;
         rsp_b_valid_q <= rsp_b_valid_d;
         rsp_r_quot_q  <= rsp_r_quot_d;
         rsp_b_quot_q  <= rsp_b_quot_d;
         tag_q         <= tag_d;
      end
   end

   assign div_a       = div_a_q;
   assign div_b       = div_b_q;
   assign div_vld     = div_vld_q;
   assign rsp_r_valid = rsp_r_valid_q;
   assign rsp_r_quot  = rsp_r_quot_q;
   assign rsp_b_valid = rsp_b_valid_q;
   assign rsp_b_quot  = rsp_b_quot_q;
   assign busy        = inflight;

`ifdef IMCOR_DIV_STATS_EN
   logic        vsync_q;
   logic        vsync_rise;
   logic        ev_dbz;
   logic [15:0] cnt_r_q, cnt_r_d, cnt_b_q, cnt_b_d, cnt_dbz_q, cnt_dbz_d;
   logic [15:0] stat_r_q, stat_r_d, stat_b_q, stat_b_d, stat_dbz_q, stat_dbz_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic ev);
      if (ev && (cnt != 16'hFFFF)) begin
         return cnt + 16'd1;
      end
      return cnt;
   endfunction

   assign vsync_rise = vsync & ~vsync_q;
   assign ev_dbz     = (tag_exit != TAG_NONE) & div_dbz;

   // On a frame edge the old totals are published and this cycle's events open the new frame.
   always_comb begin
      stat_r_d   = stat_r_q;
      stat_b_d   = stat_b_q;
      stat_dbz_d = stat_dbz_q;
      cnt_r_d    = sat_inc(cnt_r_q, gnt[0]);
      cnt_b_d    = sat_inc(cnt_b_q, gnt[1]);
      cnt_dbz_d  = sat_inc(cnt_dbz_q, ev_dbz);
      if (vsync_rise) begin
         stat_r_d   = cnt_r_q;
         stat_b_d   = cnt_b_q;
         stat_dbz_d = cnt_dbz_q;
         cnt_r_d    = {15'd0, gnt[0]};
         cnt_b_d    = {15'd0, gnt[1]};
         cnt_dbz_d  = {15'd0, ev_dbz};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         cnt_r_q    <= '0;
         cnt_b_q    <= '0;
         cnt_dbz_q  <= '0;
         stat_r_q   <= '0;
         stat_b_q   <= '0;
         stat_dbz_q <= '0;
      end else begin
         vsync_q    <= vsync;
         cnt_r_q    <= cnt_r_d;
         cnt_b_q    <= cnt_b_d;
         cnt_dbz_q  <= cnt_dbz_d;
         stat_r_q   <= stat_r_d;
         stat_b_q   <= stat_b_d;
         stat_dbz_q <= stat_dbz_d;
      end
   end

   assign stat_r_cnt   = stat_r_q;
   assign stat_b_cnt   = stat_b_q;
   assign stat_dbz_cnt = stat_dbz_q;
`else
   logic vsync_unused;
   assign vsync_unused = vsync;
`endif

endmodule

// File: tb/tb_imcor_div_arbiter.sv
// Directed and random self-checking bench for imcor_div_arbiter with a behavioural
// DIV_LAT-cycle divider; define IMCOR_DIV_STATS_EN to also exercise the frame statistics.
module tb_imcor_div_arbiter;

   localparam int DW_IN   = 10;
   localparam int DW_DEC  = 8;
   localparam int DW_Q    = DW_IN + DW_DEC;
   localparam int DIV_LAT = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            vsync = 1'b0;
   logic            req_r_valid = 1'b0, req_b_valid = 1'b0;
   logic [DW_IN-1:0] req_r_num = '0, req_r_den = '0, req_b_num = '0, req_b_den = '0;
   logic            req_r_ready, req_b_ready;
   logic [DW_Q-1:0] div_a;
   logic [DW_IN-1:0] div_b;
   logic            div_vld;
   logic [DW_Q-1:0] div_quot;
   logic            div_dbz;
   logic            rsp_r_valid, rsp_b_valid;
   logic [DW_Q-1:0] rsp_r_quot, rsp_b_quot;
   logic            busy;
`ifdef IMCOR_DIV_STATS_EN
   logic [15:0]     stat_r_cnt, stat_b_cnt, stat_dbz_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic            force_en = 1'b0;
   logic [DW_Q-1:0] force_val = '0;
   logic [DW_Q-1:0] m_quot [DIV_LAT] = '{default: '0};
   logic            m_dbz  [DIV_LAT] = '{default: 1'b0};

   imcor_div_arbiter #(.DW_IN(DW_IN), .DW_DEC(DW_DEC), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst), .vsync(vsync),
      .req_r_valid(req_r_valid), .req_r_num(req_r_num), .req_r_den(req_r_den), .req_r_ready(req_r_ready),
      .req_b_valid(req_b_valid), .req_b_num(req_b_num), .req_b_den(req_b_den), .req_b_ready(req_b_ready),
      .div_a(div_a), .div_b(div_b), .div_vld(div_vld), .div_quot(div_quot), .div_dbz(div_dbz),
      .rsp_r_valid(rsp_r_valid), .rsp_r_quot(rsp_r_quot),
      .rsp_b_valid(rsp_b_valid), .rsp_b_quot(rsp_b_quot),
      .busy(busy)
`ifdef IMCOR_DIV_STATS_EN
      , .stat_r_cnt(stat_r_cnt), .stat_b_cnt(stat_b_cnt), .stat_dbz_cnt(stat_dbz_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural divider: operands seen in cycle n produce a quotient during cycle n+DIV_LAT.
   always @(posedge clk) begin
      if (div_vld && force_en) begin
         m_quot[0] <= force_val;
         m_dbz[0]  <= 1'b0;
      end else if (div_vld && div_b == '0) begin
         m_quot[0] <= '0;
         m_dbz[0]  <= 1'b1;
      end else if (div_vld) begin
         m_quot[0] <= div_a / {{DW_DEC{1'b0}}, div_b};
         m_dbz[0]  <= 1'b0;
      end else begin
         m_quot[0] <= '0;
         m_dbz[0]  <= 1'b0;
      end
      for (int i = 1; i < DIV_LAT; i++) begin
         m_quot[i] <= m_quot[i-1];
         m_dbz[i]  <= m_dbz[i-1];
      end
   end
   assign div_quot = m_quot[DIV_LAT-1];
   assign div_dbz  = m_dbz[DIV_LAT-1];

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [DW_Q-1:0] ref_quot(input logic [DW_IN-1:0] num, input logic [DW_IN-1:0] den);
      logic [DW_Q-1:0] q;
      if (den == '0) return {{DW_IN{1'b1}}, {DW_DEC{1'b0}}};
      q = {num, {DW_DEC{1'b0}}} / {{DW_DEC{1'b0}}, den};
      if (&q[DW_Q-1:DW_DEC]) q[DW_DEC-1:0] = '0;
      return q;
   endfunction

   task automatic drive(input logic vr, input logic [DW_IN-1:0] nr, input logic [DW_IN-1:0] dr,
                        input logic vb, input logic [DW_IN-1:0] nb, input logic [DW_IN-1:0] db);
      req_r_valid = vr; req_r_num = nr; req_r_den = dr;
      req_b_valid = vb; req_b_num = nb; req_b_den = db;
   endtask

   task automatic do_reset();
      rst = 1'b1; vsync = 1'b0; force_en = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({div_vld, rsp_r_valid, rsp_b_valid, busy, req_r_ready, req_b_ready} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got %b exp 000000",
                  {div_vld, rsp_r_valid, rsp_b_valid, busy, req_r_ready, req_b_ready});
      end
      checks++;
      if ({div_a, div_b, rsp_r_quot, rsp_b_quot} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data got a=%h b=%h qr=%h qb=%h exp all 0", div_a, div_b, rsp_r_quot, rsp_b_quot);
      end
`ifdef IMCOR_DIV_STATS_EN
      checks++;
      if ({stat_r_cnt, stat_b_cnt, stat_dbz_cnt} !== 48'd0) begin
         errors++;
         $display("[TB] FAIL reset_stats got %0d/%0d/%0d exp 0/0/0", stat_r_cnt, stat_b_cnt, stat_dbz_cnt);
      end
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, div_vld} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL idle_after_reset got busy=%b vld=%b exp 0 0", busy, div_vld);
      end
   endtask

   task automatic test_single_r();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c < 3) drive(1, 10'h100, 10'h200, 0, 0, 0);
         else       drive(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         checks++;
         if ({req_r_ready, req_b_ready} !== {(c < 3), 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_ready c=%0d got %b%b exp %b0", c, req_r_ready, req_b_ready, (c < 3));
         end
         checks++;
         if ({rsp_r_valid, rsp_b_valid} !== {(c >= 6 && c <= 8), 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_rsp_valid c=%0d got %b%b exp %b0", c, rsp_r_valid, rsp_b_valid, (c >= 6 && c <= 8));
         end
         if (c >= 6 && c <= 8) begin
            checks++;
            if (rsp_r_quot !== 18'h00080) begin
               errors++;
               $display("[TB] FAIL single_quot c=%0d got %h exp 00080", c, rsp_r_quot);
            end
         end
         checks++;
         if (busy !== (c >= 1 && c <= 8)) begin
            errors++;
            $display("[TB] FAIL single_busy c=%0d got %b exp %b", c, busy, (c >= 1 && c <= 8));
         end
      end
   endtask

   task automatic test_contention();
      logic [DW_Q-1:0] exp_r, exp_b;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c < 4) drive(1, (c == 0) ? 10'h100 : 10'h080, 10'h200,
                          1, (c < 2) ? 10'h300 : 10'h010, (c < 2) ? 10'h100 : 10'h003);
         else       drive(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         checks++;
         if ({req_r_ready, req_b_ready} !== {(c == 0 || c == 2), (c == 1 || c == 3)}) begin
            errors++;
            $display("[TB] FAIL rr_ready c=%0d got %b%b exp %b%b", c, req_r_ready, req_b_ready,
                     (c == 0 || c == 2), (c == 1 || c == 3));
         end
         checks++;
         if (div_vld !== (c >= 1 && c <= 4)) begin
            errors++;
            $display("[TB] FAIL rr_div_vld c=%0d got %b exp %b", c, div_vld, (c >= 1 && c <= 4));
         end
         if (c == 1 || c == 5) begin
            checks++;
            if ({div_a, div_b} !== ((c == 1) ? {18'h10000, 10'h200} : {18'h01000, 10'h003})) begin
               errors++;
               $display("[TB] FAIL rr_operands c=%0d got a=%h b=%h", c, div_a, div_b);
            end
         end
         checks++;
         if ({rsp_r_valid, rsp_b_valid} !== {(c == 6 || c == 8), (c == 7 || c == 9)}) begin
            errors++;
            $display("[TB] FAIL rr_rsp_valid c=%0d got %b%b exp %b%b", c, rsp_r_valid, rsp_b_valid,
                     (c == 6 || c == 8), (c == 7 || c == 9));
         end
         exp_r = (c < 8) ? 18'h00080 : 18'h00040;
         exp_b = (c < 9) ? 18'h00300 : 18'h00555;
         if (c >= 6 && c <= 9) begin
            checks++;
            if (rsp_r_quot !== exp_r) begin
               errors++;
               $display("[TB] FAIL rr_quot_r c=%0d got %h exp %h", c, rsp_r_quot, exp_r);
            end
         end
         if (c >= 7 && c <= 10) begin
            checks++;
            if (rsp_b_quot !== exp_b) begin
               errors++;
               $display("[TB] FAIL rr_quot_b c=%0d got %h exp %h", c, rsp_b_quot, exp_b);
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic [DW_Q-1:0] exp_q;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         case (c)
            0:       drive(1, 10'h123, 10'h000, 0, 0, 0);
            1:       drive(1, 10'h3FF, 10'h001, 0, 0, 0);
            2:       drive(1, 10'h001, 10'h001, 0, 0, 0);
            3:       drive(1, 10'h002, 10'h001, 0, 0, 0);
            default: drive(0, 0, 0, 0, 0, 0);
         endcase
         force_en  = (c == 3 || c == 4);
         force_val = (c == 3) ? 18'h3FFAB : 18'h2AB7F;
         @(negedge clk);
         checks++;
         if (rsp_r_valid !== (c >= 6 && c <= 9)) begin
            errors++;
            $display("[TB] FAIL sat_valid c=%0d got %b exp %b", c, rsp_r_valid, (c >= 6 && c <= 9));
         end
         if (c >= 6 && c <= 9) begin
            exp_q = (c == 9) ? 18'h2AB7F : 18'h3FF00;
            checks++;
            if (rsp_r_quot !== exp_q) begin
               errors++;
               $display("[TB] FAIL sat_quot c=%0d got %h exp %h", c, rsp_r_quot, exp_q);
            end
         end
      end
      force_en = 1'b0;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int c = 0; c < 13; c++) begin
         @(posedge clk); #1;
         rst = (c == 3 || c == 4);
         case (c)
            0, 2:    drive(1, 10'h100, 10'h200, 0, 0, 0);
            1, 12:   drive(1, 10'h100, 10'h200, 1, 10'h300, 10'h100);
            default: drive(0, 0, 0, 0, 0, 0);
         endcase
         @(negedge clk);
         if (c == 1 || c == 2 || c == 12) begin
            checks++;
            if ({req_r_ready, req_b_ready} !== ((c == 1) ? 2'b01 : 2'b10)) begin
               errors++;
               $display("[TB] FAIL rst_ptr c=%0d got %b%b", c, req_r_ready, req_b_ready);
            end
         end
         if (c == 2) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL rst_busy_before got %b exp 1", busy);
            end
         end
         if (c == 3) begin
            checks++;
            if ({div_a, div_b, div_vld, rsp_r_valid, rsp_b_valid, rsp_r_quot, rsp_b_quot, busy} !== '0) begin
               errors++;
               $display("[TB] FAIL rst_outputs got a=%h b=%h vld=%b rv=%b%b busy=%b exp 0",
                        div_a, div_b, div_vld, rsp_r_valid, rsp_b_valid, busy);
            end
         end
         if (c >= 5 && c <= 11) begin
            checks++;
            if ({rsp_r_valid, rsp_b_valid, busy} !== 3'b000) begin
               errors++;
               $display("[TB] FAIL rst_no_rsp c=%0d got rv=%b%b busy=%b exp 000", c, rsp_r_valid, rsp_b_valid, busy);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [DW_Q-1:0] q_r[$];
      logic [DW_Q-1:0] q_b[$];
      logic [DW_Q-1:0] exp_q;
      logic            ptr, exp_rr, exp_rb;
      do_reset();
      ptr = 1'b0;
      for (int c = 0; c < 10012; c++) begin
         @(posedge clk); #1;
         if (c < 10000) begin
            drive(($urandom_range(0, 9) < 7), 10'($urandom), ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom),
                  ($urandom_range(0, 9) < 6), 10'($urandom), ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom));
         end else begin
            drive(0, 0, 0, 0, 0, 0);
         end
         @(negedge clk);
         exp_rr = req_r_valid && (!req_b_valid || !ptr);
         exp_rb = req_b_valid && !exp_rr;
         checks++;
         if (req_r_ready && req_b_ready) begin
            errors++;
            $display("[TB] FAIL rand_both_ready c=%0d got 11 exp at most one", c);
         end
         checks++;
         if ({req_r_ready, req_b_ready} !== {exp_rr, exp_rb}) begin
            errors++;
            $display("[TB] FAIL rand_ready c=%0d got %b%b exp %b%b", c, req_r_ready, req_b_ready, exp_rr, exp_rb);
         end
         if (exp_rr) begin q_r.push_back(ref_quot(req_r_num, req_r_den)); ptr = 1'b1; end
         if (exp_rb) begin q_b.push_back(ref_quot(req_b_num, req_b_den)); ptr = 1'b0; end
         if (rsp_r_valid) begin
            checks++;
            exp_q = (q_r.size() > 0) ? q_r.pop_front() : 'x;
            if (rsp_r_quot !== exp_q) begin
               errors++;
               $display("[TB] FAIL rand_quot_r c=%0d got %h exp %h", c, rsp_r_quot, exp_q);
            end
         end
         if (rsp_b_valid) begin
            checks++;
            exp_q = (q_b.size() > 0) ? q_b.pop_front() : 'x;
            if (rsp_b_quot !== exp_q) begin
               errors++;
               $display("[TB] FAIL rand_quot_b c=%0d got %h exp %h", c, rsp_b_quot, exp_q);
            end
         end
      end
      checks++;
      if (q_r.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("[TB] FAIL rand_drain got pending r=%0d b=%0d exp 0 0", q_r.size(), q_b.size());
      end
   endtask

`ifdef IMCOR_DIV_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int c = 0; c < 33; c++) begin
         @(posedge clk); #1;
         vsync = (c < 3) || (c >= 20 && c < 23) || (c >= 30);
         if ((c >= 2 && c <= 6) || c == 20) drive(1, 10'h020, 10'h010, 0, 0, 0);
         else if (c >= 8 && c <= 10)        drive(0, 0, 0, 1, 10'h040, (c == 8) ? 10'h000 : 10'h001);
         else                               drive(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (c == 1 || c == 21 || c == 31) begin
            checks++;
            if ({stat_r_cnt, stat_b_cnt, stat_dbz_cnt} !==
                ((c == 1) ? {16'd0, 16'd0, 16'd0} : (c == 21) ? {16'd5, 16'd3, 16'd1} : {16'd1, 16'd0, 16'd0})) begin
               errors++;
               $display("[TB] FAIL stats c=%0d got %0d/%0d/%0d", c, stat_r_cnt, stat_b_cnt, stat_dbz_cnt);
            end
         end
      end
      vsync = 1'b0;
   endtask
`endif

   initial begin
      $display("[TB] start");
      test_reset();
      test_single_r();
      test_contention();
      test_saturation();
      test_reset_inflight();
`ifdef IMCOR_DIV_STATS_EN
      test_stats();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
